// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module : mips_ctrl_pkg
// Brief  : Shared types and encodings for the multi-cycle MIPS control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_LW_WB     = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;

    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT = 2'b10;

    localparam logic [1:0] c_SRCB_B      = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mips_stall_timer.sv
// ============================================================================
// Module : mips_stall_timer
// Brief  : Saturating memory-stall counter with sticky timeout flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_stall_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic waiting_i,
    input  logic state_change_i,
    output logic err_o
);

    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
    logic             r_err_q, r_err_d;

    always_comb begin
        r_cnt_d = r_cnt_q;
        if (state_change_i) begin
            r_cnt_d = '0;
        end else if (waiting_i && (r_cnt_q != {CNT_W{1'b1}})) begin
            r_cnt_d = r_cnt_q + 1'b1;
        end
        // flag rises on the edge where the count reaches the limit
        r_err_d = r_err_q | ((TIMEOUT != 0) && (r_cnt_d == c_LIMIT));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt_q <= '0;
            r_err_q <= 1'b0;
        end else begin
            r_cnt_q <= r_cnt_d;
            r_err_q <= r_err_d;
        end
    end

    assign err_o = r_err_q;

endmodule

`default_nettype wire

// File: rtl/mips_mc_control_fsm.sv
// ============================================================================
// Module : mips_mc_control_fsm
// Brief  : Multi-cycle MIPS main control FSM with memory-ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_mc_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W          = 6,
    parameter int MEM_HANDSHAKE = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [OP_W-1:0] OPCODE,
    input  logic            ZERO,
    input  logic            MEM_READY,
    output logic            PC_WRITE,
    output logic            PC_WRITE_COND,
    output logic            IOR_D,
    output logic            MEM_READ,
    output logic            MEM_WRITE,
    output logic            MEM_TO_REG,
    output logic            IR_WRITE,
    output logic            ALU_SRC_A,
    output logic            REG_WRITE,
    output logic            REG_DST,
    output logic [1:0]      PC_SOURCE,
    output logic [1:0]      ALU_OP,
    output logic [1:0]      ALU_SRC_B,
    output logic            INSTR_DONE,
    output logic            ILLEGAL_OP,
    output logic            ERR_TIMEOUT
);

    state_e state_q, state_d;
    logic   w_rdy, w_waiting, w_err, w_zero_unused;

    assign w_rdy         = MEM_READY | (MEM_HANDSHAKE == 0);
    assign w_zero_unused = ZERO;
    assign w_waiting     = ~w_rdy & ((state_q == S_FETCH) | (state_q == S_MEM_RD) |
                                     (state_q == S_MEM_WR));

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        if (!RST) begin
            case (state_q)
                S_FETCH:     state_d = w_rdy ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    if      (OPCODE == OP_W'(c_OP_LW) || OPCODE == OP_W'(c_OP_SW)) state_d = S_MEM_ADDR;
                    else if (OPCODE == OP_W'(c_OP_R))    state_d = S_R_EXEC;
                    else if (OPCODE == OP_W'(c_OP_BEQ))  state_d = S_BRANCH;
                    else if (OPCODE == OP_W'(c_OP_J))    state_d = S_JUMP;
                    else if (OPCODE == OP_W'(c_OP_ADDI)) state_d = S_ADDI_EXEC;
                    else                                 state_d = S_FETCH;
                end
                S_MEM_ADDR: begin
                    if      (OPCODE == OP_W'(c_OP_LW)) state_d = S_MEM_RD;
                    else if (OPCODE == OP_W'(c_OP_SW)) state_d = S_MEM_WR;
                    else                               state_d = S_FETCH;
                end
                S_MEM_RD:    state_d = w_rdy ? S_LW_WB : S_MEM_RD;
                S_MEM_WR:    state_d = w_rdy ? S_FETCH : S_MEM_WR;
                S_R_EXEC:    state_d = S_R_WB;
                S_ADDI_EXEC: state_d = S_ADDI_WB;
                default:     state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        PC_WRITE      = 1'b0;
        PC_WRITE_COND = 1'b0;
        IOR_D         = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_TO_REG    = 1'b0;
        IR_WRITE      = 1'b0;
        ALU_SRC_A     = 1'b0;
        REG_WRITE     = 1'b0;
        REG_DST       = 1'b0;
        PC_SOURCE     = c_PCSRC_ALU;
        ALU_OP        = c_ALU_ADD;
        ALU_SRC_B     = c_SRCB_B;
        INSTR_DONE    = 1'b0;
        ILLEGAL_OP    = 1'b0;
        if (!RST) begin
            case (state_q)
                S_FETCH: begin
                    MEM_READ  = 1'b1;
                    ALU_SRC_B = c_SRCB_FOUR;
                    IR_WRITE  = w_rdy;
                    PC_WRITE  = w_rdy;
                end
                S_DECODE: begin
                    ALU_SRC_B = c_SRCB_IMM_SH;
                    if (state_d == S_FETCH) begin
                        ILLEGAL_OP = 1'b1;
                        INSTR_DONE = 1'b1;
                    end
                end
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    ALU_SRC_A = 1'b1;
                    ALU_SRC_B = c_SRCB_IMM;
                end
                S_MEM_RD: begin
                    MEM_READ = 1'b1;
                    IOR_D    = 1'b1;
                end
                S_LW_WB: begin
                    REG_WRITE  = 1'b1;
                    MEM_TO_REG = 1'b1;
                    INSTR_DONE = 1'b1;
                end
                S_MEM_WR: begin
                    MEM_WRITE  = 1'b1;
                    IOR_D      = 1'b1;
                    INSTR_DONE = w_rdy;
                end
                S_R_EXEC: begin
                    ALU_SRC_A = 1'b1;
                    ALU_OP    = c_ALU_FUNCT;
                end
                S_R_WB: begin
                    REG_WRITE  = 1'b1;
                    REG_DST    = 1'b1;
                    INSTR_DONE = 1'b1;
                end
                S_BRANCH: begin
                    ALU_SRC_A     = 1'b1;
                    ALU_OP        = c_ALU_SUB;
                    PC_WRITE_COND = 1'b1;
                    PC_SOURCE     = c_PCSRC_ALUOUT;
                    INSTR_DONE    = 1'b1;
                end
                S_JUMP: begin
                    PC_WRITE   = 1'b1;
                    PC_SOURCE  = c_PCSRC_JUMP;
                    INSTR_DONE = 1'b1;
                end
                S_ADDI_WB: begin
                    REG_WRITE  = 1'b1;
                    INSTR_DONE = 1'b1;
                end
                default: ;
            endcase
        end
    end

    mips_stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_timer (
        .CLK            (CLK),
        .RST            (RST),
        .waiting_i      (w_waiting),
        .state_change_i (state_d != state_q),
        .err_o          (w_err)
    );

    assign ERR_TIMEOUT = w_err & ~RST;

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_control_fsm.sv
// ============================================================================
// Module : tb_mips_mc_control_fsm
// Brief  : Self-checking bench; instruction-sequence model plus directed checks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_mc_control_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] OPCODE = 6'd0;
    logic       ZERO = 1'b0;
    logic       MEM_READY = 1'b1;
    logic       PC_WRITE, PC_WRITE_COND, IOR_D, MEM_READ, MEM_WRITE, MEM_TO_REG;
    logic       IR_WRITE, ALU_SRC_A, REG_WRITE, REG_DST;
    logic [1:0] PC_SOURCE, ALU_OP, ALU_SRC_B;
    logic       INSTR_DONE, ILLEGAL_OP, ERR_TIMEOUT;

    int n_checks = 0;
    int n_pass   = 0;

    mips_mc_control_fsm #(
        .OP_W          (6),
        .MEM_HANDSHAKE (1),
        .TIMEOUT       (4)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .OPCODE        (OPCODE),
        .ZERO          (ZERO),
        .MEM_READY     (MEM_READY),
        .PC_WRITE      (PC_WRITE),
        .PC_WRITE_COND (PC_WRITE_COND),
        .IOR_D         (IOR_D),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_TO_REG    (MEM_TO_REG),
        .IR_WRITE      (IR_WRITE),
        .ALU_SRC_A     (ALU_SRC_A),
        .REG_WRITE     (REG_WRITE),
        .REG_DST       (REG_DST),
        .PC_SOURCE     (PC_SOURCE),
        .ALU_OP        (ALU_OP),
        .ALU_SRC_B     (ALU_SRC_B),
        .INSTR_DONE    (INSTR_DONE),
        .ILLEGAL_OP    (ILLEGAL_OP),
        .ERR_TIMEOUT   (ERR_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    logic [18:0] w_dut;
    assign w_dut = {PC_WRITE, PC_WRITE_COND, IOR_D, MEM_READ, MEM_WRITE, MEM_TO_REG,
                    IR_WRITE, ALU_SRC_A, REG_WRITE, REG_DST, PC_SOURCE, ALU_OP,
                    ALU_SRC_B, INSTR_DONE, ILLEGAL_OP, ERR_TIMEOUT};

    // Model: each instruction is a string of phase letters walked one per cycle.
    // F fetch, D decode, A addr, R mem read, L lw wb, W mem write,
    // X r exec, Y r wb, B branch, J jump, I addi exec, K addi wb.
    string m_seq   = "FD";
    int    m_step  = 0;
    int    m_stall = 0;
    bit    m_err   = 1'b0;

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    function automatic string seq_of(input logic [5:0] op);
        case (op)
            6'b100011: return "FDARL";
            6'b101011: return "FDAW";
            6'b000000: return "FDXY";
            6'b000100: return "FDB";
            6'b000010: return "FDJ";
            6'b001000: return "FDIK";
            default:   return "FD";
        endcase
    endfunction

    function automatic logic [18:0] exp_vec(input byte p, input bit ill, input bit rdy, input bit err);
        logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, m2r = 0, irw = 0;
        logic sa = 0, rw = 0, rd = 0, done = 0, il = 0;
        logic [1:0] pcs = 0, aop = 0, sb = 0;
        case (p)
            "F": begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            "D": begin sb = 2'b11; il = ill; done = ill; end
            "A", "I": begin sa = 1; sb = 2'b10; end
            "R": begin mr = 1; iord = 1; end
            "L": begin rw = 1; m2r = 1; done = 1; end
            "W": begin mw = 1; iord = 1; done = rdy; end
            "X": begin sa = 1; aop = 2'b10; end
            "Y": begin rw = 1; rd = 1; done = 1; end
            "B": begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            "J": begin pcw = 1; pcs = 2'b10; done = 1; end
            "K": begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, m2r, irw, sa, rw, rd, pcs, aop, sb, done, il, err};
    endfunction

    always @(posedge CLK) begin
        byte   p;
        bit    w;
        string s;
        int    st, sc;
        bit    e;
        if (RST) begin
            m_seq <= "FD"; m_step <= 0; m_stall <= 0; m_err <= 1'b0;
        end else begin
            s = m_seq; st = m_step; sc = m_stall; e = m_err;
            p = s[st];
            w = (p inside {"F", "R", "W"}) && !MEM_READY;
            if (w) begin
                if (sc < 255) sc = sc + 1;
                if (sc == 4) e = 1'b1;
            end else begin
                sc = 0;
                if (p == "D") s = seq_of(OPCODE);
                st = st + 1;
                if (st >= s.len()) begin st = 0; s = "FD"; end
            end
            m_seq <= s; m_step <= st; m_stall <= sc; m_err <= e;
        end
    end

    always @(negedge CLK) begin
        logic [18:0] ev;
        byte p;
        #2;
        p  = m_seq[m_step];
        ev = RST ? 19'd0 : exp_vec(p, (p == "D") && !legal(OPCODE), MEM_READY, m_err);
        n_checks++;
        if (w_dut === ev) n_pass++;
        else $display("FAIL model t=%0t phase=%s got=%05h want=%05h", $time, p, w_dut, ev);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    endtask

    task automatic cyc(input bit r, input logic [5:0] op, input bit rdy);
        @(negedge CLK);
        #1;
        RST = r; OPCODE = op; MEM_READY = rdy;
        #2;
    endtask

    int mw_cnt, done_cnt;

    initial begin
        cyc(1, 6'd0, 1);
        cyc(1, 6'd0, 1);
        chk("reset_outputs_zero", {5'd0, (w_dut == 19'd0)}, 8'd1);

        // LW, no stalls
        cyc(0, 6'b100011, 1);
        chk("fetch_mem_read", MEM_READ, 1);
        chk("fetch_ir_pc_write", {IR_WRITE, PC_WRITE}, 8'b11);
        chk("fetch_src_b", ALU_SRC_B, 8'b01);
        for (int i = 2; i <= 5; i++) begin
            cyc(0, 6'b100011, 1);
            chk("lw_reg_write", REG_WRITE, (i == 5) ? 8'd1 : 8'd0);
            chk("lw_done", INSTR_DONE, (i == 5) ? 8'd1 : 8'd0);
        end
        chk("lw_mem_to_reg", MEM_TO_REG, 1);

        // SW with three stalled cycles in MEM_WR
        mw_cnt = 0; done_cnt = 0;
        cyc(0, 6'b101011, 1);
        cyc(0, 6'b101011, 1);
        cyc(0, 6'b101011, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 6'b101011, (i == 3));
            mw_cnt += int'(MEM_WRITE);
            done_cnt += int'(INSTR_DONE);
        end
        chk("sw_write_cycles", 8'(mw_cnt), 8'd4);
        chk("sw_done_last_only", {INSTR_DONE, 7'(done_cnt)}, {1'b1, 7'd1});

        // BEQ then J
        cyc(0, 6'b000100, 1);
        chk("sw_then_fetch", MEM_READ, 1);
        cyc(0, 6'b000100, 1);
        cyc(0, 6'b000100, 1);
        chk("beq_ctrl", {PC_WRITE_COND, ALU_OP, PC_SOURCE}, {3'd0, 1'b1, 2'b01, 2'b01});
        cyc(0, 6'b000010, 1);
        cyc(0, 6'b000010, 1);
        cyc(0, 6'b000010, 1);
        chk("jump_ctrl", {PC_WRITE, PC_SOURCE}, {5'd0, 1'b1, 2'b10});

        // R-type and ADDI
        for (int i = 0; i < 4; i++) cyc(0, 6'b000000, 1);
        chk("r_wb_dst", {REG_WRITE, REG_DST}, 8'b11);
        for (int i = 0; i < 4; i++) cyc(0, 6'b001000, 1);
        chk("addi_wb", {REG_WRITE, REG_DST, INSTR_DONE}, 8'b101);

        // Illegal opcode
        cyc(0, 6'b111111, 1);
        cyc(0, 6'b111111, 1);
        chk("illegal_pulse", {ILLEGAL_OP, INSTR_DONE}, 8'b11);

        // Stall FETCH past the timeout of 4
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 6'b100011, 0);
            if (i == 1) chk("illegal_then_fetch", MEM_READ, 1);
            if (i == 5) chk("err_rises", ERR_TIMEOUT, 1);
            if (i == 4) chk("err_not_yet", ERR_TIMEOUT, 0);
        end
        cyc(0, 6'b100011, 1);
        cyc(0, 6'b100011, 1);
        cyc(0, 6'b100011, 1);
        cyc(0, 6'b100011, 0);
        chk("err_sticky", ERR_TIMEOUT, 1);
        cyc(0, 6'b100011, 0);
        cyc(1, 6'b100011, 0);
        chk("reset_midstall_zero", {5'd0, (w_dut == 19'd0)}, 8'd1);
        cyc(0, 6'b100011, 1);
        chk("post_reset_fetch", {MEM_READ, IR_WRITE, ERR_TIMEOUT}, 8'b110);

        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
